// File: rtl/moddiv_pkg.sv
// Shared definitions for the binary modular-division controller.
//   state_t        : controller FSM states
//   DEF_W          : default operand width
//   def_max_iter() : default RUN-operation limit for a given width
package moddiv_pkg;

   localparam int DEF_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DONE
   } state_t;

   // The binary GCD finishes in at most about 2*W halvings plus subtracts.
   // 4*W leaves comfortable headroom before declaring a timeout.
   function automatic int def_max_iter(input int w);
      return 4 * w;
   endfunction

endpackage

// File: rtl/moddiv_ctrl.sv
// Control FSM for the binary modular-division core (x = a/b mod p).
//   clk, rst           : clock and synchronous active-high reset
//   start              : request a new division (accepted only in IDLE)
//   u_/v_ status bits  : logical u/v comparator results from the datapath
//   load, u_flag_rst   : datapath load and u-flag force, asserted in LOAD
//   u_flag_set         : swap the u/v roles via the u-flag
//   op_half_u/v, op_sub: datapath operation strobes
//   busy, done         : activity indication and completion pulse
//   err, result_sel    : outcome, held until the next accepted start
module moddiv_ctrl
   import moddiv_pkg::*;
#(
   parameter int W        = DEF_W,
   parameter int MAX_ITER = def_max_iter(W),
   parameter int CW       = $clog2(MAX_ITER + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic u_is_zero,
   input  logic v_is_zero,
   input  logic u_is_one,
   input  logic v_is_one,
   input  logic u_even,
   input  logic v_even,
   input  logic u_ge_v,
   output logic load,
   output logic u_flag_rst,
   output logic u_flag_set,
   output logic op_half_u,
   output logic op_half_v,
   output logic op_sub,
   output logic busy,
   output logic done,
   output logic err,
   output logic result_sel
);

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          err_d, sel_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         err        <= 1'b0;
         result_sel <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         err        <= err_d;
         result_sel <= sel_d;
      end
   end

   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      err_d      = err;
      sel_d      = result_sel;
      load       = 1'b0;
      u_flag_rst = 1'b0;
      u_flag_set = 1'b0;
      op_half_u  = 1'b0;
      op_half_v  = 1'b0;
      op_sub     = 1'b0;
      busy       = (state != ST_IDLE);
      done       = (state == ST_DONE);

      case (state)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
               err_d   = 1'b0;
               sel_d   = 1'b0;
            end
         end
         ST_LOAD: begin
            load       = 1'b1;
            u_flag_rst = 1'b1;
            cnt_d      = '0;
            state_d    = ST_RUN;
         end
         ST_RUN: begin
            // Termination checks take precedence over any datapath op.
            // The limit check sits ahead of the op decode, so the count
            // stops at MAX_ITER and can never wrap.
            if (u_is_zero || v_is_zero) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (u_is_one) begin
               sel_d   = 1'b0;
               state_d = ST_DONE;
            end else if (v_is_one) begin
               sel_d   = 1'b1;
               state_d = ST_DONE;
            end else if (cnt == CW'(MAX_ITER)) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt + CW'(1);
               if (u_even)       op_half_u  = 1'b1;
               else if (v_even)  op_half_v  = 1'b1;
               else if (!u_ge_v) u_flag_set = 1'b1;
               else              op_sub     = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_moddiv_ctrl.sv
// Self-checking bench for moddiv_ctrl: a small logical u/v datapath model
// feeds the status bits, a scoreboard of expected outcomes is checked at done.
module tb_moddiv_ctrl;

   logic clk = 1'b0;
   logic rst, start;
   logic u_is_zero, v_is_zero, u_is_one, v_is_one, u_even, v_even, u_ge_v;
   logic load, u_flag_rst, u_flag_set, op_half_u, op_half_v, op_sub;
   logic busy, done, err, result_sel;

   always #5 clk = ~clk;

   moddiv_ctrl dut (
      .clk(clk), .rst(rst), .start(start),
      .u_is_zero(u_is_zero), .v_is_zero(v_is_zero),
      .u_is_one(u_is_one), .v_is_one(v_is_one),
      .u_even(u_even), .v_even(v_even), .u_ge_v(u_ge_v),
      .load(load), .u_flag_rst(u_flag_rst), .u_flag_set(u_flag_set),
      .op_half_u(op_half_u), .op_half_v(op_half_v), .op_sub(op_sub),
      .busy(busy), .done(done), .err(err), .result_sel(result_sel)
   );

   typedef struct {
      int e_err; int e_sel; int e_ops; int e_hu; int e_swap;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] opb_q[$];
   logic [31:0] opp_q[$];

   int n_cmp = 0, n_mis = 0;
   int cyc = 0, load_cyc = 0, nloads = 0, ndone = 0;
   int c_ops = 0, c_hu = 0, c_swap = 0, s;
   bit force_even = 0;
   logic [31:0] mu = 0, mv = 0;

   task automatic chk(input string tag, input int obs, input int expv);
      n_cmp++;
      if (obs !== expv) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // Logical u/v status derived from the model; force_even pins u even.
   assign u_is_zero = force_even ? 1'b0 : (mu == 0);
   assign v_is_zero = force_even ? 1'b0 : (mv == 0);
   assign u_is_one  = force_even ? 1'b0 : (mu == 1);
   assign v_is_one  = force_even ? 1'b0 : (mv == 1);
   assign u_even    = force_even ? 1'b1 : ~mu[0];
   assign v_even    = ~mv[0];
   assign u_ge_v    = (mu >= mv);

   always @(posedge clk) cyc++;

   // Datapath model: only the logical u and v matter to the controller.
   always @(posedge clk) begin
      if (!rst) begin
         if (load) begin
            if (opb_q.size() > 0) begin
               mu <= opb_q.pop_front();
               mv <= opp_q.pop_front();
            end
         end else if (u_flag_set) begin
            mu <= mv; mv <= mu;
         end else if (op_half_u) mu <= mu >> 1;
         else if (op_half_v)     mv <= mv >> 1;
         else if (op_sub)        mu <= mu - mv;
      end
   end

   // Monitor: strobe legality, per-run counts, scoreboard check at done.
   always @(negedge clk) begin
      if (!rst) begin
         s = int'(load) + int'(u_flag_set) + int'(op_half_u) + int'(op_half_v) + int'(op_sub);
         if (s > 1) chk("strobe_excl", s, 1);
         if (u_flag_rst !== load) chk("ufr_with_load", u_flag_rst, load);
         if (!busy && s != 0) chk("strobe_idle", s, 0);
         if (load) begin
            nloads++;
            load_cyc = cyc;
            c_ops = 0; c_hu = 0; c_swap = 0;
            chk("ld_err_clr", err, 0);
            chk("ld_sel_clr", result_sel, 0);
         end
         if (op_half_u) c_hu++;
         if (u_flag_set) c_swap++;
         if (op_half_u | op_half_v | op_sub | u_flag_set) c_ops++;
         if (done) begin
            exp_t e;
            ndone++;
            chk("done_busy", busy, 1);
            if (exp_q.size() == 0) chk("sb_empty", 0, 1);
            else begin
               e = exp_q.pop_front();
               chk("err", err, e.e_err);
               chk("sel", result_sel, e.e_sel);
               chk("nops", c_ops, e.e_ops);
               chk("nhalfu", c_hu, e.e_hu);
               chk("nswap", c_swap, e.e_swap);
               chk("latency", cyc - load_cyc, e.e_ops + 2);
            end
         end
      end
   end

   task automatic push(input logic [31:0] b, input logic [31:0] p,
                       input int e_err, input int e_sel, input int e_ops,
                       input int e_hu, input int e_swap);
      exp_t e;
      e.e_err = e_err; e.e_sel = e_sel; e.e_ops = e_ops;
      e.e_hu = e_hu; e.e_swap = e_swap;
      exp_q.push_back(e);
      opb_q.push_back(b);
      opp_q.push_back(p);
   endtask

   task automatic wait_done(input int budget);
      int n0 = ndone;
      int i  = 0;
      while (ndone == n0 && i < budget) begin
         @(posedge clk); i++;
      end
      if (ndone == n0) chk("timeout", ndone, n0 + 1);
   endtask

   task automatic wait_load(input int target, input int budget);
      int i = 0;
      while (nloads < target && i < budget) begin
         @(posedge clk); i++;
      end
      if (nloads < target) chk("load_timeout", nloads, target);
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic run(input logic [31:0] b, input logic [31:0] p,
                      input int e_err, input int e_sel, input int e_ops,
                      input int e_hu, input int e_swap);
      push(b, p, e_err, e_sel, e_ops, e_hu, e_swap);
      pulse_start();
      wait_done(300);
      @(posedge clk);
   endtask

   initial begin
      int l0;
      rst = 1'b1; start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_sel", result_sel, 0);
      chk("rst_load", load, 0);
      rst = 1'b0;

      // u already one: no ops, done two cycles after LOAD
      run(32'd1, 32'd7, 0, 0, 0, 0, 0);
      // swap, sub, half, half
      run(32'd3, 32'd7, 0, 0, 4, 2, 1);
      // v already one: answer in y
      run(32'd7, 32'd1, 0, 1, 0, 0, 0);
      // u zero: error, held in IDLE
      run(32'd0, 32'd7, 1, 0, 0, 0, 0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("err_hold", err, 1);
      chk("idle_busy", busy, 0);

      // u forced even forever: timeout after the full op limit
      force_even = 1'b1;
      run(32'd6, 32'd7, 1, 0, 128, 128, 0);
      force_even = 1'b0;

      // start during RUN is ignored
      l0 = nloads;
      push(32'd3, 32'd7, 0, 0, 4, 2, 1);
      pulse_start();
      wait_load(l0 + 1, 20);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_done(50);
      repeat (4) @(posedge clk);
      chk("ignored_start", nloads, l0 + 1);

      // reset in the middle of RUN
      force_even = 1'b1;
      l0 = nloads;
      push(32'd6, 32'd7, 1, 0, 128, 128, 0);
      pulse_start();
      wait_load(l0 + 1, 20);
      repeat (10) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_strobe", int'(op_half_u | op_half_v | op_sub | u_flag_set | load), 0);
      chk("mrst_err", err, 0);
      rst = 1'b0;
      force_even = 1'b0;
      void'(exp_q.pop_back());
      run(32'd1, 32'd7, 0, 0, 0, 0, 0);

      // back-to-back with start held: second run accepted right after DONE
      l0 = nloads;
      push(32'd7, 32'd1, 0, 1, 0, 0, 0);
      push(32'd0, 32'd7, 1, 0, 0, 0, 0);
      @(negedge clk); start = 1'b1;
      wait_done(50);
      wait_load(l0 + 2, 10);
      @(negedge clk); start = 1'b0;
      wait_done(50);
      repeat (3) @(posedge clk);
      chk("b2b_loads", nloads, l0 + 2);
      chk("sb_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/moddiv_ctrl.md
Name: moddiv_ctrl

Overview:
- Control FSM for the binary modular-division core. It computes x = a/b mod p using binary-GCD style iterations.
- It sits directly upstream of the u-flag register, driving `u_flag_rst` and `u_flag_set`, and of the u/v/x/y datapath, driving the op strobes.
- It consumes comparator/status bits from the datapath. These always describe the logical u and v, already resolved through the u-flag.
- It sequences load, halve/swap/subtract iterations and termination, and reports done, the error condition and which result register holds the answer.

Parameters:
- W, 32, operand width in bits. Informational; sets the default iteration limit.
- MAX_ITER, 4*W, maximum RUN-state operations before the timeout error.
- CW, $clog2(MAX_ITER+1), iteration counter width.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request a new division. Sampled only in IDLE.
- u_is_zero  in  1  logical u == 0
- v_is_zero  in  1  logical v == 0
- u_is_one  in  1  logical u == 1
- v_is_one  in  1  logical v == 1
- u_even  in  1  logical u[0] == 0
- v_even  in  1  logical v[0] == 0
- u_ge_v  in  1  logical u >= v
- load  out  1  datapath loads u=b, v=p, x=a, y=0
- u_flag_rst  out  1  forces the u-flag to 1 (u held in regu)
- u_flag_set  out  1  toggles the u-flag; swaps the (u,x) and (v,y) roles
- op_half_u  out  1  u >>= 1, x = x/2 mod p
- op_half_v  out  1  v >>= 1, y = y/2 mod p
- op_sub  out  1  u = u - v, x = x - y mod p
- busy  out  1  high from LOAD through DONE inclusive
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; held until the next accepted start
- result_sel  out  1  0 = result in x, 1 = result in y; held until the next accepted start

Behaviour:
- States: IDLE, LOAD, RUN, DONE.
- Reset (rst=1 at an edge):
  - state goes to IDLE; all strobes 0; busy=0, done=0, err=0, result_sel=0; iteration count = 0.
  - Reset wins over every other condition, including mid-RUN. The datapath is not cleared.
- IDLE:
  - start=1 → LOAD. start in any other state is ignored; there is no queueing.
  - In the accepting cycle, err and result_sel clear to 0.
- LOAD (exactly one cycle):
  - load=1 and u_flag_rst=1 together; iteration count := 0.
  - Next state is RUN.
- RUN:
  - Each cycle, status is evaluated and at most one strobe is asserted, combinationally from state plus status.
  - The datapath and u-flag update at the following edge; status is valid again the next cycle.
  - Priority, first match wins:
    1. u_is_zero or v_is_zero → err:=1, go to DONE, no strobe.
    2. u_is_one → result_sel:=0, go to DONE.
    3. v_is_one → result_sel:=1, go to DONE.
    4. count == MAX_ITER → err:=1, go to DONE.
    5. u_even → op_half_u.
    6. v_even → op_half_v.
    7. !u_ge_v → u_flag_set (swap, 1 cycle).
    8. Otherwise → op_sub.
  - Items 5–8 increment the count by 1; the count never wraps.
- DONE (one cycle): done=1, busy=1, then IDLE. err and result_sel stay valid.
- Invariant: op_half_u, op_half_v, op_sub, u_flag_set, load are mutually exclusive and never asserted outside LOAD/RUN.
- Latency: start sampled at edge k → LOAD in cycle k+1 → first RUN cycle k+2. With N ops, done is high in cycle k+3+N.
- p must be odd and gcd(b,p)=1. A violation surfaces as u or v reaching 0, which is reported via err.

Decomposition:
- Shared package moddiv_pkg holds:
  - state enum (IDLE, LOAD, RUN, DONE);
  - the default W;
  - a function giving the default MAX_ITER.
- Single module, no sub-module.
- The strobe decode is a combinational always block within it; the flag register remains the existing separate block.

Test Plan:
- a=1, b=1, p=7 (u_is_one in first RUN) → zero strobes; done in cycle k+3; err=0, result_sel=0.
- b=3, p=7, bench datapath model → strobe sequence u_flag_set, op_sub, op_half_u, op_half_u; exactly one u_flag_set; done at k+7; result_sel=0.
- b=0 (u_is_zero in first RUN) → no op strobes; done with err=1; err held until the next start.
- Bench holds u_even=1 and never asserts *_is_one → exactly MAX_ITER (128) op_half_u pulses, then done with err=1.
- start pulsed during RUN → ignored, sequence unchanged. rst asserted mid-RUN → next cycle IDLE, all outputs 0; a fresh start then runs normally from LOAD with u_flag_rst=1.
- Back-to-back: start held high through DONE → a new LOAD the cycle after IDLE is re-entered; err/result_sel cleared at acceptance.
